simon_arbiter: RTL and testbench

- Round-robin scheduler that shares one SIMON_control core between NREQ requesters (host packet channels).
- Captures the winning request, then drives the core's newDATA/newKEY handshake and waits for doneDATA.
- Returns the result to the owning requester, then acknowledges the core with readDATA.
- Sits between the packet front-end and SIMON_control; one transaction in flight at a time.

---
 rtl/simon_arb_pkg.sv | 15 +
 rtl/simon_rr_pick.sv | 30 +++
 rtl/simon_arbiter.sv | 168 ++++++++++++++++
 tb/tb_simon_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_arb_pkg.sv
// Shared types and constants for the SIMON core arbiter.
// Word sizes follow the SIMON32/64 definitions: 16-bit words, 4 key words.
package simon_arb_pkg;

   localparam int BLK_N = 16;
   localparam int BLK_M = 4;

   localparam int TIMEOUT_W = 8;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

   typedef logic [2*BLK_N-1:0]     blk_t;
   typedef logic [BLK_M*BLK_N-1:0] key_t;

endpackage

// File: rtl/simon_rr_pick.sv
// Pointer-rotated priority encoder: first set request at or above ptr, wrapping.
module simon_rr_pick #(
   parameter  int NREQ  = 4,
   localparam int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   output logic [PTR_W-1:0] grant,
   output logic             any
);

   int               idx;
   logic [PTR_W-1:0] idx_w;

   // Scan from the farthest offset down so the nearest requester is written last.
   always_comb begin
      grant = '0;
      idx   = 0;
      idx_w = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_w = PTR_W'(idx);
         if (req[idx_w]) grant = idx_w;
      end
   end

   assign any = |req;

endmodule

// File: rtl/simon_arbiter.sv
// Round-robin scheduler sharing one SIMON_control core between NREQ packet channels.
// Define KEY_CACHE_EN to skip key reloads when the requested key matches the last loaded one.
//
// state | meaning
// IDLE  | waiting for any request; newDATA/newKEY held low
// ISSUE | newDATA/newKEY held until the core signals loadDATA/loadKEY
// WAIT  | core computing; abort after TIMEOUT cycles
// RESP  | result presented to owner until rsp_ready[owner]
module simon_arbiter
   import simon_arb_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int N       = BLK_N,
   parameter int M       = BLK_M,
   parameter int TIMEOUT = 255
) (
   input  logic                      clk,
   input  logic                      nR,
   input  logic [NREQ-1:0]           req,
   input  logic [NREQ-1:0][2*N-1:0]  req_data,
   input  logic [NREQ-1:0][M*N-1:0]  req_key,
   input  logic [NREQ-1:0][7:0]      req_info,
   input  logic [NREQ-1:0][7:0]      req_count,
   output logic [NREQ-1:0]           ack,
   output logic [NREQ-1:0]           rsp_valid,
   input  logic [NREQ-1:0]           rsp_ready,
   output logic [2*N-1:0]            rsp_data,
   output logic [7:0]                rsp_info,
   output logic [7:0]                rsp_count,
   output logic                      rsp_err,
   output logic                      core_newDATA,
   output logic                      core_newKEY,
   output logic [2*N-1:0]            core_inDATA,
   output logic [M*N-1:0]            core_KEY,
   output logic [7:0]                core_infoIN,
   output logic [7:0]                core_countIN,
   output logic                      core_readDATA,
   input  logic                      core_loadDATA,
   input  logic                      core_loadKEY,
   input  logic                      core_doneDATA,
   input  logic [2*N-1:0]            core_outDATA,
   input  logic [7:0]                core_infoOUT,
   input  logic [7:0]                core_countOUT
);

   localparam int PTR_W = $clog2(NREQ);

   arb_state_t           state;
   logic [PTR_W-1:0]     ptr;
   logic [PTR_W-1:0]     owner;
   logic [PTR_W-1:0]     grant;
   logic                 any_req;
   logic [TIMEOUT_W-1:0] wait_cnt;
   logic                 nd_next;
   logic                 nk_next;

   assign nd_next = core_newDATA & ~core_loadDATA;
   assign nk_next = core_newKEY  & ~core_loadKEY;

   simon_rr_pick #(.NREQ(NREQ)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .grant (grant),
      .any   (any_req)
   );

`ifdef KEY_CACHE_EN
   logic [M*N-1:0] last_key;
   logic           key_valid;
`endif

   always_ff @(posedge clk or negedge nR) begin
      if (!nR) begin
         state         <= IDLE;
         ptr           <= '0;
         owner         <= '0;
         wait_cnt      <= '0;
         ack           <= '0;
         rsp_valid     <= '0;
         rsp_data      <= '0;
         rsp_info      <= '0;
         rsp_count     <= '0;
         rsp_err       <= 1'b0;
         core_newDATA  <= 1'b0;
         core_newKEY   <= 1'b0;
         core_inDATA   <= '0;
         core_KEY      <= '0;
         core_infoIN   <= '0;
         core_countIN  <= '0;
         core_readDATA <= 1'b0;
`ifdef KEY_CACHE_EN
         last_key      <= '0;
         key_valid     <= 1'b0;
`endif
      end else begin
         ack           <= '0;
         core_readDATA <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  owner        <= grant;
                  core_inDATA  <= req_data[grant];
                  core_KEY     <= req_key[grant];
                  core_infoIN  <= req_info[grant];
                  core_countIN <= req_count[grant];
                  ack[grant]   <= 1'b1;
                  core_newDATA <= 1'b1;
`ifdef KEY_CACHE_EN
                  core_newKEY  <= !key_valid || (req_key[grant] != last_key);
`else
                  core_newKEY  <= 1'b1;
`endif
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               core_newDATA <= nd_next;
               core_newKEY  <= nk_next;
`ifdef KEY_CACHE_EN
               if (core_newKEY && core_loadKEY) begin
                  last_key  <= core_KEY;
                  key_valid <= 1'b1;
               end
`endif
               if (!nd_next && !nk_next) begin
                  state    <= WAIT;
                  wait_cnt <= TIMEOUT_W'(TIMEOUT - 1);
               end
            end
            WAIT: begin
               // doneDATA takes priority over an expiring timer.
               if (core_doneDATA) begin
                  rsp_data         <= core_outDATA;
                  rsp_info         <= core_infoOUT;
                  rsp_count        <= core_countOUT;
                  rsp_err          <= 1'b0;
                  core_readDATA    <= 1'b1;
                  rsp_valid        <= '0;
                  rsp_valid[owner] <= 1'b1;
                  state            <= RESP;
               end else if (wait_cnt == '0) begin
                  rsp_data         <= '0;
                  rsp_info         <= core_infoIN;
                  rsp_count        <= core_countIN;
                  rsp_err          <= 1'b1;
                  rsp_valid        <= '0;
                  rsp_valid[owner] <= 1'b1;
`ifdef KEY_CACHE_EN
                  key_valid        <= 1'b0;
`endif
                  state            <= RESP;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready[owner]) begin
                  rsp_valid <= '0;
                  ptr       <= (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_simon_arbiter.sv
// Bench for simon_arbiter: vector table, corner sequences and random traffic
// against a round-robin reference model with a behavioural core stand-in.
module tb_simon_arbiter;
   import simon_arb_pkg::*;

   localparam int NREQ    = 4;
   localparam int N       = BLK_N;
   localparam int M       = BLK_M;
   localparam int TIMEOUT = 255;

   logic clk = 1'b0;
   logic nR  = 1'b0;

   logic [NREQ-1:0]          req       = '0;
   logic [NREQ-1:0][2*N-1:0] req_data  = '0;
   logic [NREQ-1:0][M*N-1:0] req_key   = '0;
   logic [NREQ-1:0][7:0]     req_info  = '0;
   logic [NREQ-1:0][7:0]     req_count = '0;
   logic [NREQ-1:0]          rsp_ready = '0;
   logic [NREQ-1:0]          ack, rsp_valid;
   logic [2*N-1:0]           rsp_data;
   logic [7:0]               rsp_info, rsp_count;
   logic                     rsp_err;
   logic                     core_newDATA, core_newKEY, core_readDATA;
   logic [2*N-1:0]           core_inDATA;
   logic [M*N-1:0]           core_KEY;
   logic [7:0]               core_infoIN, core_countIN;
   logic                     core_loadDATA = 1'b0, core_loadKEY = 1'b0, core_doneDATA = 1'b0;
   logic [2*N-1:0]           core_outDATA  = '0;
   logic [7:0]               core_infoOUT  = '0, core_countOUT = '0;

   int tests  = 0;
   int failed = 0;

   simon_arbiter #(.NREQ(NREQ), .N(N), .M(M), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .nR(nR), .req(req), .req_data(req_data), .req_key(req_key),
      .req_info(req_info), .req_count(req_count), .ack(ack), .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_info(rsp_info),
      .rsp_count(rsp_count), .rsp_err(rsp_err), .core_newDATA(core_newDATA),
      .core_newKEY(core_newKEY), .core_inDATA(core_inDATA), .core_KEY(core_KEY),
      .core_infoIN(core_infoIN), .core_countIN(core_countIN),
      .core_readDATA(core_readDATA), .core_loadDATA(core_loadDATA),
      .core_loadKEY(core_loadKEY), .core_doneDATA(core_doneDATA),
      .core_outDATA(core_outDATA), .core_infoOUT(core_infoOUT),
      .core_countOUT(core_countOUT)
   );

   always #5 clk = ~clk;

   // Core stand-in: the published SIMON32/64 vector, otherwise a cheap keyed mix.
   function automatic blk_t core_f(input blk_t d, input key_t k);
      if (d == 32'h6565_6877 && k == 64'h1918_1110_0908_0100) return 32'hc69b_e9bb;
      return {d[15:0], d[31:16]} ^ k[31:0] ^ 32'h1357_9bdf;
   endfunction

   int done_lat   = 2;
   int key_lat    = 1;
   bit never_done = 1'b0;
   int kd   = 0;
   int dcnt = 0;
   bit busy = 1'b0;

   always @(negedge clk or negedge nR) begin
      if (!nR) begin
         core_loadDATA = 1'b0;
         core_loadKEY  = 1'b0;
         core_doneDATA = 1'b0;
         busy = 1'b0;
         kd   = 0;
      end else begin
         core_loadDATA = core_newDATA;
         if (core_newKEY) begin
            core_loadKEY = (kd >= key_lat);
            kd++;
         end else begin
            core_loadKEY = 1'b0;
            kd = 0;
         end
         if (core_newDATA) begin
            busy          = 1'b1;
            dcnt          = done_lat;
            core_outDATA  = core_f(core_inDATA, core_KEY);
            core_infoOUT  = core_infoIN ^ 8'h10;
            core_countOUT = core_countIN;
            core_doneDATA = 1'b0;
         end else if (busy) begin
            if (core_doneDATA && core_readDATA) begin
               core_doneDATA = 1'b0;
               busy = 1'b0;
            end else if (!never_done) begin
               if (dcnt == 0) core_doneDATA = 1'b1;
               else dcnt--;
            end
         end
      end
   end

   int nk_rises = 0;
   bit nk_prev  = 1'b0;
   always @(negedge clk) begin
      if (core_newKEY && !nk_prev) nk_rises++;
      nk_prev = core_newKEY;
   end

   // Reference model state.
   int   ptr_m  = 0;
   int   exp_nk = 0;
   bit   kv_m   = 1'b0;
   key_t last_m = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] mask);
      for (int k = 0; k < NREQ; k++)
         if (mask[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
      return -1;
   endfunction

   task automatic rand_inputs();
      for (int c = 0; c < NREQ; c++) begin
         req_data[c]  = (2*N)'($urandom);
         req_key[c]   = {$urandom, $urandom};
         req_info[c]  = 8'($urandom);
         req_count[c] = 8'($urandom);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ack_valid"}, {56'd0, ack, rsp_valid}, 64'd0);
      check({tag, "_rsp"}, {15'd0, rsp_err, rsp_count, rsp_info, rsp_data}, 64'd0);
      check({tag, "_core_ctl"}, {61'd0, core_newDATA, core_newKEY, core_readDATA}, 64'd0);
      check({tag, "_core_data"}, {16'd0, core_countIN, core_infoIN, core_inDATA}, 64'd0);
      check({tag, "_core_key"}, core_KEY, 64'd0);
   endtask

   // Caller is positioned just after a falling edge with the arbiter in IDLE.
   task automatic run_txn(input logic [NREQ-1:0] mask, input int exp_g_in, input bit exp_to,
                          input int ready_delay, input logic [NREQ-1:0] pend_mask);
      int   exp_g, cyc, to_cyc;
      bit   got, stable;
      blk_t d;
      key_t k;
      logic [7:0] inf, cnt;
      logic [NREQ-1:0] oh;
      logic [2*N-1:0] rd;
      logic [7:0] ri, rc;
      logic re;

      exp_g = (exp_g_in < 0) ? model_pick(mask) : exp_g_in;
      d   = req_data[exp_g];
      k   = req_key[exp_g];
      inf = req_info[exp_g];
      cnt = req_count[exp_g];
      oh  = '0;
      oh[exp_g] = 1'b1;
`ifdef KEY_CACHE_EN
      if (!kv_m || k != last_m) exp_nk++;
      last_m = k;
      kv_m   = !exp_to;
`else
      exp_nk++;
`endif
      never_done = exp_to;
      req = mask;
      got = 1'b0;
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         if (ack != '0) begin
            got = 1'b1;
            break;
         end
      end
      check("ack_latency", 64'(cyc), 64'(got ? 1 : 99));
      check("ack_grant", 64'(ack), 64'(oh));
      check("issue_newDATA", 64'(core_newDATA), 64'd1);
      check("latched_data", {core_countIN, core_infoIN, 16'd0, core_inDATA}, {cnt, inf, 16'd0, d});
      check("latched_key", core_KEY, k);
      req = '0;
      rand_inputs();

      got = 1'b0;
      to_cyc = 0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (i == 0) check("ack_pulse", 64'(ack), 64'd0);
         if (rsp_valid != '0) begin
            got = 1'b1;
            break;
         end
         if (!core_newDATA && !core_newKEY) to_cyc++;
      end
      check("rsp_seen", 64'(got), 64'd1);
      check("rsp_valid_onehot", 64'(rsp_valid), 64'(oh));
      check("rsp_count", 64'(rsp_count), 64'(cnt));
      if (exp_to) begin
         check("to_err", 64'(rsp_err), 64'd1);
         check("to_data", 64'(rsp_data), 64'd0);
         check("to_info", 64'(rsp_info), 64'(inf));
         check("to_cycles", 64'(to_cyc), 64'(TIMEOUT));
      end else begin
         check("rsp_err", 64'(rsp_err), 64'd0);
         check("rsp_data", 64'(rsp_data), 64'(core_f(d, k)));
         check("rsp_info", 64'(rsp_info), 64'(inf ^ 8'h10));
      end
      never_done = 1'b0;

      rd = rsp_data; ri = rsp_info; rc = rsp_count; re = rsp_err;
      stable = 1'b1;
      for (int r = 0; r < ready_delay; r++) begin
         rsp_ready = ~oh;
         req = pend_mask;
         @(negedge clk);
         if (rsp_valid !== oh || rsp_data !== rd || rsp_info !== ri ||
             rsp_count !== rc || rsp_err !== re || ack !== '0) stable = 1'b0;
      end
      if (ready_delay > 0) check("rsp_hold_stable", 64'(stable), 64'd1);
      rsp_ready = oh;
      @(negedge clk);
      rsp_ready = '0;
      check("rsp_drop", 64'(rsp_valid), 64'd0);
      ptr_m = (exp_g + 1) % NREQ;
   endtask

   typedef struct {
      logic [NREQ-1:0] mask;
      int              grant;
   } vec_t;

   vec_t tbl[12];
   key_t pool[2];
   int   nk0;

   initial begin
      tbl[0]  = '{4'b1111, 0};
      tbl[1]  = '{4'b1111, 1};
      tbl[2]  = '{4'b1111, 2};
      tbl[3]  = '{4'b1111, 3};
      tbl[4]  = '{4'b1111, 0};
      tbl[5]  = '{4'b0001, 0};
      tbl[6]  = '{4'b1001, 3};
      tbl[7]  = '{4'b0110, 1};
      tbl[8]  = '{4'b0011, 0};
      tbl[9]  = '{4'b1100, 2};
      tbl[10] = '{4'b0100, 2};
      tbl[11] = '{4'b1010, 3};

      rand_inputs();
      #12;
      check_all_zero("reset");
      @(negedge clk);
      nR = 1'b1;

      for (int i = 0; i < 12; i++) begin
         rand_inputs();
         done_lat = $urandom_range(0, 5);
         key_lat  = $urandom_range(0, 3);
         run_txn(tbl[i].mask, tbl[i].grant, 1'b0, 0, '0);
      end

      // Published SIMON32/64 vector through channel 2, encrypt bit set.
      rand_inputs();
      req_data[2] = 32'h6565_6877;
      req_key[2]  = 64'h1918_1110_0908_0100;
      req_info[2] = 8'h40;
      run_txn(4'b0100, 2, 1'b0, 0, '0);

      // Core never finishes, then the following request still goes through.
      rand_inputs();
      run_txn(4'b0010, -1, 1'b1, 0, '0);
      rand_inputs();
      run_txn(4'b0010, -1, 1'b0, 0, '0);

      // Requester stalls the response for 20 cycles while another channel waits.
      rand_inputs();
      run_txn(4'b0001, -1, 1'b0, 20, 4'b1000);
      rand_inputs();
      run_txn(4'b1000, 3, 1'b0, 0, '0);

      // Reset while WAITing: pointer returns to 0, channel 1 wins over 2.
      rand_inputs();
      run_txn(4'b0010, 1, 1'b0, 0, '0);
      rand_inputs();
      never_done = 1'b1;
      req = 4'b0100;
      @(negedge clk);
      check("pre_reset_ack", 64'(ack), 64'b0100);
      exp_nk++;
      req = 4'b0110;
      repeat (6) @(negedge clk);
      #2 nR = 1'b0;
      #1 check_all_zero("mid_reset");
      @(negedge clk);
      never_done = 1'b0;
      nR = 1'b1;
      ptr_m = 0;
      kv_m  = 1'b0;
      rand_inputs();
      run_txn(4'b0110, 1, 1'b0, 0, '0);

`ifdef KEY_CACHE_EN
      rand_inputs();
      nk0 = nk_rises;
      req_key[2] = 64'h0123_4567_89ab_cdef;
      run_txn(4'b0100, 2, 1'b0, 0, '0);
      req_key[3] = 64'h0123_4567_89ab_cdef;
      run_txn(4'b1000, 3, 1'b0, 0, '0);
      check("cache_same_key", 64'(nk_rises - nk0), 64'd1);
      req_key[0] = 64'hfedc_ba98_7654_3210;
      run_txn(4'b0001, 0, 1'b0, 0, '0);
      check("cache_new_key", 64'(nk_rises - nk0), 64'd2);
`endif

      pool[0] = {$urandom, $urandom};
      pool[1] = {$urandom, $urandom};
      for (int t = 0; t < 40; t++) begin
         rand_inputs();
         for (int c = 0; c < NREQ; c++) req_key[c] = pool[$urandom_range(0, 1)];
         done_lat = $urandom_range(0, 6);
         key_lat  = $urandom_range(0, 3);
         run_txn(4'($urandom_range(1, 15)), -1, ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 3), '0);
      end

      check("newKEY_rises", 64'(nk_rises), 64'(exp_nk));

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1);
   end

endmodule
